// File: rtl/dot_acc_fifo.sv
// rtl/dot_acc_fifo.sv - sums ACC_LEN dot-product results per frame and queues frame sums on a valid/ready stream
module dot_acc_fifo #(
  parameter int IN_W       = 18,
  parameter int ACC_LEN    = 4,
  parameter int OUT_W      = IN_W + $clog2(ACC_LEN),
  parameter int DEPTH      = 4,
  parameter bit DROP_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [IN_W-1:0]        in_data,
  input  logic                   in_valid,
  input  logic                   clr,
  output logic [OUT_W-1:0]       m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [7:0]             drop_cnt
);

  localparam int CW = $clog2(ACC_LEN);
  localparam int AW = $clog2(DEPTH);

  logic [OUT_W-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_skip;
  logic [OUT_W-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             r_overflow;
  logic [7:0]       r_drop_cnt;

  logic             w_accept;
  logic             w_last;
  logic [OUT_W-1:0] w_base;
  logic [OUT_W-1:0] w_sum;
  logic             w_frame_done;
  logic [AW:0]      w_level;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;

  // The upstream stage emits a bogus zero on its first run; r_skip swallows it.
  assign w_accept     = in_valid && !clr && !r_skip;
  assign w_last       = (r_cnt == CW'(ACC_LEN - 1));
  assign w_base       = (r_cnt == '0) ? {OUT_W{1'b0}} : r_acc;
  assign w_sum        = w_base + OUT_W'(in_data);
  assign w_frame_done = w_accept && w_last;

  assign w_level = r_wr_ptr - r_rd_ptr;
  assign w_full  = (w_level == (AW+1)'(DEPTH));
  assign w_empty = (w_level == '0);
  assign w_pop   = !w_empty && m_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign w_push  = w_frame_done && (!w_full || w_pop);
  assign w_drop  = w_frame_done && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_skip <= DROP_FIRST;
    end else if (clr) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (in_valid) begin
      if (r_skip) begin
        r_skip <= 1'b0;
      end else begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= w_sum;
        r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 8'hFF) begin
          r_drop_cnt <= r_drop_cnt + 8'd1;
        end
      end
    end
  end

  assign m_data   = r_mem[r_rd_ptr[AW-1:0]];
  assign m_valid  = !w_empty;
  assign level    = w_level;
  assign overflow = r_overflow;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_dot_acc_fifo.sv
// tb/tb_dot_acc_fifo.sv - randomized and directed self-checking bench for dot_acc_fifo
module tb_dot_acc_fifo;

  localparam int IN_W    = 18;
  localparam int ACC_LEN = 4;
  localparam int OUT_W   = 20;
  localparam int DEPTH   = 4;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic [IN_W-1:0]  in_data = '0;
  logic             in_valid = 1'b0;
  logic             clr = 1'b0;
  logic             m_ready = 1'b0;
  logic [OUT_W-1:0] m_data;
  logic             m_valid;
  logic [2:0]       level;
  logic             overflow;
  logic [7:0]       drop_cnt;

  dot_acc_fifo #(
    .IN_W(IN_W), .ACC_LEN(ACC_LEN), .OUT_W(OUT_W), .DEPTH(DEPTH), .DROP_FIRST(1'b1)
  ) dut (
    .clk(clk), .resetn(resetn), .in_data(in_data), .in_valid(in_valid), .clr(clr),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .level(level), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: frames as lists of samples, FIFO as a queue.
  int q_m[$];
  int frame_m[$];
  bit skip_m;
  bit ovf_m;
  int drops_m;
  bit started = 1'b0;
  int log_q[$];
  bit stall_p = 1'b0;
  int held_p;

  always @(posedge clk) begin
    if (started && resetn && stall_p) chk("hold_stable", m_data, held_p);
    stall_p = resetn && m_valid && !m_ready;
    held_p  = m_data;
    if (resetn && m_valid && m_ready) log_q.push_back(int'(m_data));

    if (!resetn) begin
      q_m.delete();
      frame_m.delete();
      skip_m  = 1'b1;
      ovf_m   = 1'b0;
      drops_m = 0;
      started = 1'b1;
    end else begin
      bit full, popped, have;
      int sum;
      full   = (q_m.size() == DEPTH);
      popped = (q_m.size() != 0) && m_ready;
      have   = 1'b0;
      sum    = 0;
      if (clr) frame_m.delete();
      else if (in_valid) begin
        if (skip_m) skip_m = 1'b0;
        else begin
          frame_m.push_back(int'(in_data));
          if (frame_m.size() == ACC_LEN) begin
            foreach (frame_m[i]) sum += frame_m[i];
            have = 1'b1;
            frame_m.delete();
          end
        end
      end
      if (popped) void'(q_m.pop_front());
      if (have) begin
        if (!full || popped) q_m.push_back(sum);
        else begin
          ovf_m = 1'b1;
          if (drops_m < 255) drops_m++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("m_valid", m_valid, q_m.size() != 0);
      chk("level", level, q_m.size());
      if (q_m.size() != 0) chk("m_data", m_data, q_m[0]);
      chk("overflow", overflow, ovf_m);
      chk("drop_cnt", drop_cnt, drops_m);
    end
  end

  function automatic int logv(input int i);
    return (log_q.size() > i) ? log_q[i] : -1;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int d);
    @(negedge clk);
    in_data  = IN_W'(d);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn   = 1'b0;
    in_valid = 1'b0;
    clr      = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  int t1[5] = '{0, 10, 20, 30, 40};
  int exp6[$];
  bit tog_on;

  initial begin
    // Reset state and the first-sample discard
    do_reset();
    chk("rst_level", level, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_drops", drop_cnt, 0);
    m_ready = 1'b1;
    log_q.delete();
    foreach (t1[i]) begin
      pulse(t1[i]);
      cyc(5);
    end
    cyc(3);
    chk("t1_count", log_q.size(), 1);
    chk("t1_sum", logv(0), 100);
    chk("t1_level", level, 0);

    // Overflow with maximum-value samples
    do_reset();
    m_ready = 1'b0;
    log_q.delete();
    pulse(1);
    repeat (20) pulse(195075);
    cyc(2);
    chk("t2_level", level, 4);
    chk("t2_ovf", overflow, 1);
    chk("t2_drops", drop_cnt, 1);
    chk("t2_head", m_data, 780300);
    m_ready = 1'b1;
    cyc(6);
    m_ready = 1'b0;
    chk("t2_count", log_q.size(), 4);
    for (int i = 0; i < 4; i++) chk("t2_pop", logv(i), 780300);
    chk("t2_level0", level, 0);
    chk("t2_ovf_sticky", overflow, 1);

    // Push and pop in the same cycle on a full FIFO
    do_reset();
    m_ready = 1'b0;
    log_q.delete();
    pulse(7);
    repeat (4) begin
      pulse(1); pulse(2); pulse(3); pulse(4);
    end
    pulse(10); pulse(20); pulse(30);
    @(negedge clk);
    in_data  = IN_W'(40);
    in_valid = 1'b1;
    m_ready  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    m_ready  = 1'b0;
    chk("t3_level", level, 4);
    chk("t3_drops", drop_cnt, 0);
    chk("t3_popped", log_q.size(), 1);
    m_ready = 1'b1;
    cyc(6);
    chk("t3_count", log_q.size(), 5);
    chk("t3_first", logv(0), 10);
    chk("t3_last", logv(4), 100);

    // clr flushes the partial frame and ignores a coincident sample
    do_reset();
    m_ready = 1'b1;
    log_q.delete();
    pulse(3);
    pulse(5);
    pulse(6);
    @(negedge clk);
    in_data  = IN_W'(99);
    in_valid = 1'b1;
    clr      = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    clr      = 1'b0;
    pulse(1); pulse(2); pulse(3); pulse(4);
    cyc(3);
    chk("t4_count", log_q.size(), 1);
    chk("t4_sum", logv(0), 10);

    // Reset mid-frame with a non-empty FIFO re-arms the skip
    do_reset();
    m_ready = 1'b0;
    pulse(9);
    repeat (10) pulse(1);
    chk("t5_pre_level", level, 2);
    do_reset();
    chk("t5_level", level, 0);
    chk("t5_valid", m_valid, 0);
    chk("t5_ovf", overflow, 0);
    m_ready = 1'b1;
    log_q.delete();
    pulse(50);
    repeat (4) pulse(1);
    cyc(3);
    chk("t5_count", log_q.size(), 1);
    chk("t5_sum", logv(0), 4);

    // Twelve random frames with m_ready toggling, wrapping the pointers
    do_reset();
    log_q.delete();
    exp6.delete();
    pulse(0);
    tog_on  = 1'b1;
    m_ready = 1'b1;
    fork
      begin
        while (tog_on) begin
          @(negedge clk);
          m_ready = !m_ready;
        end
      end
      begin
        for (int f = 0; f < 12; f++) begin
          int s, acc;
          acc = 0;
          for (int k = 0; k < ACC_LEN; k++) begin
            s = int'($urandom_range(0, 195075));
            acc += s;
            pulse(s);
            cyc(int'($urandom_range(0, 2)));
          end
          exp6.push_back(acc);
        end
        cyc(20);
        tog_on = 1'b0;
      end
    join
    chk("t6_count", log_q.size(), 12);
    foreach (exp6[i]) chk("t6_order", logv(i), exp6[i]);
    chk("t6_drops", drop_cnt, 0);

    // Fully random traffic against the model
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      resetn   = ($urandom_range(0, 399) != 0);
      in_valid = $urandom_range(0, 1) == 1;
      in_data  = IN_W'($urandom_range(0, 195075));
      clr      = ($urandom_range(0, 31) == 0);
      m_ready  = ($urandom_range(0, 3) == 0) ^ ((n / 200) % 2 == 1);
    end
    @(negedge clk);
    resetn   = 1'b1;
    in_valid = 1'b0;
    clr      = 1'b0;
    cyc(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
